// File: rtl/lock_pkg.sv
// Shared state encodings and code-digit extraction for the parametrised combination lock.
package lock_pkg;

   localparam logic [2:0] ENTRY   = 3'd0;
   localparam logic [2:0] CLOSED  = 3'd1;
   localparam logic [2:0] OPEN    = 3'd2;
   localparam logic [2:0] PROG    = 3'd3;
   localparam logic [2:0] LOCKOUT = 3'd4;

   // Upper bounds for the generic helper; callers zero-extend their code into this width.
   localparam int LOCK_MAX_CW = 256;
   localparam int LOCK_MAX_DW = 32;

   function automatic logic [LOCK_MAX_DW-1:0] digit_at(input logic [LOCK_MAX_CW-1:0] code,
                                                      input int unsigned            i,
                                                      input int unsigned            dw);
      logic [LOCK_MAX_CW-1:0] sh;
      logic [LOCK_MAX_DW-1:0] r;
      sh = code >> (i * dw);
      r  = sh[LOCK_MAX_DW-1:0];
      for (int b = 0; b < LOCK_MAX_DW; b++) begin
         if (b >= int'(dw)) r[b] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/lock_code_reg.sv
// Active code register plus the shadow register that collects a new code while programming.
module lock_code_reg
   import lock_pkg::*;
#(
   parameter int                          DIGITS       = 6,
   parameter int                          DIGIT_W      = 4,
   parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE = 24'h518384
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [$clog2(DIGITS)-1:0]   wr_idx,
   input  logic [DIGIT_W-1:0]          wr_digit,
   input  logic                        commit,
   input  logic [$clog2(DIGITS)-1:0]   rd_idx,
   output logic [DIGIT_W-1:0]          rd_digit
);

   localparam int CW = DIGITS * DIGIT_W;

   logic [CW-1:0] code_q, code_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic [CW-1:0] merged;

   // Writing digit 0 starts a fresh pass, so stale digits from an aborted pass never leak into a commit.
   always_comb begin
      merged = (wr_en && wr_idx == '0) ? '0 : shadow_q;
      if (wr_en) merged[int'(wr_idx)*DIGIT_W +: DIGIT_W] = wr_digit;
      shadow_d = commit ? '0 : merged;
      code_d   = commit ? merged : code_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q   <= DEFAULT_CODE;
         shadow_q <= '0;
      end else begin
         code_q   <= code_d;
         shadow_q <= shadow_d;
      end
   end

   assign rd_digit = DIGIT_W'(digit_at(LOCK_MAX_CW'(code_q), int'(rd_idx), DIGIT_W));

endmodule

// File: rtl/param_lock_fsm.sv
// Parametrised combination lock: digit entry with retry limit and lockout, plus code re-programming.
module param_lock_fsm
   import lock_pkg::*;
#(
   parameter int                          DIGITS       = 6,
   parameter int                          DIGIT_W      = 4,
   parameter int                          MAX_DIGIT    = 9,
   parameter int                          MAX_TRIES    = 3,
   parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE = 24'h518384
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DIGIT_W-1:0]                digit_i,
   input  logic                              enter_i,
   input  logic                              cancel_i,
   input  logic                              relock_i,
   input  logic                              prog_i,
   output logic [2:0]                        state_o,
   output logic [$clog2(DIGITS)-1:0]         idx_o,
   output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt_o,
   output logic                              err_o
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam int FC_W  = $clog2(MAX_TRIES + 1);

   logic [2:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FC_W-1:0]    fail_q, fail_d;
   logic               err_q, err_d;
   logic               mis_q, mis_d;

   logic               wr_en, commit;
   logic [DIGIT_W-1:0] rd_digit;
   logic               digit_ok, last, mis_now;
   logic [FC_W-1:0]    fail_inc;

   lock_code_reg #(
      .DIGITS       (DIGITS),
      .DIGIT_W      (DIGIT_W),
      .DEFAULT_CODE (DEFAULT_CODE)
   ) u_code (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_idx   (idx_q),
      .wr_digit (digit_i),
      .commit   (commit),
      .rd_idx   (idx_q),
      .rd_digit (rd_digit)
   );

   assign digit_ok = (digit_i <= DIGIT_W'(MAX_DIGIT));
   assign last     = (idx_q == IDX_W'(DIGITS - 1));
   assign mis_now  = mis_q | (digit_i != rd_digit);
   assign fail_inc = (fail_q < FC_W'(MAX_TRIES)) ? fail_q + FC_W'(1) : fail_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fail_d  = fail_q;
      err_d   = 1'b0;
      mis_d   = mis_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ENTRY: begin
            if (cancel_i) begin
               idx_d = '0;
               mis_d = 1'b0;
            end else if (enter_i) begin
               if (!digit_ok) begin
                  err_d = 1'b1;
               end else if (last) begin
                  idx_d = '0;
                  mis_d = 1'b0;
                  if (!mis_now) begin
                     state_d = OPEN;
                     fail_d  = '0;
                  end else begin
                     fail_d  = fail_inc;
                     state_d = (fail_inc >= FC_W'(MAX_TRIES)) ? LOCKOUT : CLOSED;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  mis_d = mis_now;
               end
            end
         end
         CLOSED: begin
            if (cancel_i) begin
               state_d = ENTRY;
               idx_d   = '0;
            end
         end
         OPEN: begin
            if (relock_i) begin
               state_d = ENTRY;
               idx_d   = '0;
            end else if (prog_i) begin
               state_d = PROG;
               idx_d   = '0;
            end
         end
         PROG: begin
            if (cancel_i) begin
               state_d = OPEN;
               idx_d   = '0;
            end else if (enter_i) begin
               if (!digit_ok) begin
                  err_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  if (last) begin
                     commit  = 1'b1;
                     idx_d   = '0;
                     state_d = OPEN;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         end
         LOCKOUT: state_d = LOCKOUT;
         default: state_d = LOCKOUT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ENTRY;
         idx_q   <= '0;
         fail_q  <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign state_o    = state_q;
   assign idx_o      = idx_q;
   assign fail_cnt_o = fail_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_param_lock_fsm.sv
// Scoreboard bench for param_lock_fsm: directed strobes with hand-computed expected outputs.
module tb_param_lock_fsm;
   import lock_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digit_i = '0;
   logic       enter_i = 1'b0, cancel_i = 1'b0, relock_i = 1'b0, prog_i = 1'b0;
   logic [2:0] state_o;
   logic [2:0] idx_o;
   logic [1:0] fail_cnt_o;
   logic       err_o;

   param_lock_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .digit_i    (digit_i),
      .enter_i    (enter_i),
      .cancel_i   (cancel_i),
      .relock_i   (relock_i),
      .prog_i     (prog_i),
      .state_o    (state_o),
      .idx_o      (idx_o),
      .fail_cnt_o (fail_cnt_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [2:0] st;
      logic [2:0] idx;
      logic [1:0] fc;
      logic       err;
      string      nm;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input string fld, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, fld, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.due < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s.late: got cycle %0d expected cycle %0d", e.nm, cyc, e.due);
         end else begin
            chk(e.nm, "state", int'(state_o), int'(e.st));
            chk(e.nm, "idx", int'(idx_o), int'(e.idx));
            chk(e.nm, "fail_cnt", int'(fail_cnt_o), int'(e.fc));
            chk(e.nm, "err", int'(err_o), int'(e.err));
         end
      end
   end

   task automatic drive(input logic r, input logic [3:0] d, input logic en, input logic ca,
                        input logic rl, input logic pg, input logic [2:0] est,
                        input logic [2:0] eidx, input logic [1:0] efc, input logic eerr,
                        input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; digit_i = d; enter_i = en; cancel_i = ca; relock_i = rl; prog_i = pg;
      x.due = cyc + 1; x.st = est; x.idx = eidx; x.fc = efc; x.err = eerr; x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic enter_d(input logic [3:0] d, input logic [2:0] est, input logic [2:0] eidx,
                          input logic [1:0] efc, input logic eerr, input string nm);
      drive(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, est, eidx, efc, eerr, nm);
   endtask

   task automatic strobe(input logic ca, input logic rl, input logic pg, input logic [2:0] est,
                         input logic [2:0] eidx, input logic [1:0] efc, input string nm);
      drive(1'b0, 4'd0, 1'b0, ca, rl, pg, est, eidx, efc, 1'b0, nm);
   endtask

   // Six digits, digit 0 in the low nibble; idx steps 1..5 then wraps to 0 with the outcome.
   task automatic seq6(input logic [23:0] code, input logic [2:0] mid_st, input logic [2:0] end_st,
                       input logic [1:0] mid_fc, input logic [1:0] end_fc, input string nm);
      for (int k = 0; k < 6; k++) begin
         if (k < 5) enter_d(code[k*4 +: 4], mid_st, 3'(k + 1), mid_fc, 1'b0, nm);
         else       enter_d(code[k*4 +: 4], end_st, 3'd0, end_fc, 1'b0, nm);
      end
   endtask

   initial begin
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, 1'b0, "reset");
      strobe(1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, "idle_after_reset");

      seq6(24'h518384, ENTRY, OPEN, 2'd0, 2'd0, "open_default");
      strobe(1'b0, 1'b1, 1'b0, ENTRY, 3'd0, 2'd0, "relock");

      seq6(24'h618384, ENTRY, CLOSED, 2'd0, 2'd1, "wrong_last");
      enter_d(4'd4, CLOSED, 3'd0, 2'd1, 1'b0, "closed_ignores_enter");
      strobe(1'b1, 1'b0, 1'b0, ENTRY, 3'd0, 2'd1, "closed_cancel");
      seq6(24'h518384, ENTRY, OPEN, 2'd1, 2'd0, "retry_open");
      strobe(1'b0, 1'b1, 1'b0, ENTRY, 3'd0, 2'd0, "relock2");

      enter_d(4'd4, ENTRY, 3'd1, 2'd0, 1'b0, "abort_d0");
      enter_d(4'd8, ENTRY, 3'd2, 2'd0, 1'b0, "abort_d1");
      enter_d(4'd9, ENTRY, 3'd3, 2'd0, 1'b0, "abort_d2_wrong");
      drive(1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, 1'b0, "cancel_beats_enter");
      seq6(24'h518384, ENTRY, OPEN, 2'd0, 2'd0, "open_after_abort");
      strobe(1'b0, 1'b1, 1'b0, ENTRY, 3'd0, 2'd0, "relock3");

      seq6(24'h518389, ENTRY, CLOSED, 2'd0, 2'd1, "wrong_first");
      strobe(1'b1, 1'b0, 1'b0, ENTRY, 3'd0, 2'd1, "cancel_t1");
      seq6(24'h618384, ENTRY, CLOSED, 2'd1, 2'd2, "wrong_t2");
      strobe(1'b1, 1'b0, 1'b0, ENTRY, 3'd0, 2'd2, "cancel_t2");
      seq6(24'h518380, ENTRY, LOCKOUT, 2'd2, 2'd3, "wrong_t3_lockout");
      strobe(1'b1, 1'b0, 1'b0, LOCKOUT, 3'd0, 2'd3, "lockout_cancel");
      for (int k = 0; k < 6; k++) begin
         logic [23:0] c;
         c = 24'h518384;
         enter_d(c[k*4 +: 4], LOCKOUT, 3'd0, 2'd3, 1'b0, "lockout_correct");
      end
      enter_d(4'd12, LOCKOUT, 3'd0, 2'd3, 1'b0, "lockout_no_err");
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, 1'b0, "reset_lockout");
      strobe(1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, "idle2");

      enter_d(4'd4, ENTRY, 3'd1, 2'd0, 1'b0, "inv_d0");
      enter_d(4'd12, ENTRY, 3'd1, 2'd0, 1'b1, "inv_digit_err");
      strobe(1'b0, 1'b0, 1'b0, ENTRY, 3'd1, 2'd0, "err_one_cycle");
      enter_d(4'd8, ENTRY, 3'd2, 2'd0, 1'b0, "inv_d1");
      enter_d(4'd3, ENTRY, 3'd3, 2'd0, 1'b0, "inv_d2");
      enter_d(4'd8, ENTRY, 3'd4, 2'd0, 1'b0, "inv_d3");
      enter_d(4'd1, ENTRY, 3'd5, 2'd0, 1'b0, "inv_d4");
      enter_d(4'd5, OPEN, 3'd0, 2'd0, 1'b0, "inv_open");

      enter_d(4'd4, OPEN, 3'd0, 2'd0, 1'b0, "open_ignores_enter");
      strobe(1'b1, 1'b0, 1'b0, OPEN, 3'd0, 2'd0, "open_ignores_cancel");
      strobe(1'b0, 1'b0, 1'b1, PROG, 3'd0, 2'd0, "prog_enter");
      enter_d(4'd9, PROG, 3'd1, 2'd0, 1'b0, "prog_p0");
      enter_d(4'd9, PROG, 3'd2, 2'd0, 1'b0, "prog_p1");
      enter_d(4'd14, PROG, 3'd2, 2'd0, 1'b1, "prog_inv_err");
      strobe(1'b1, 1'b0, 1'b0, OPEN, 3'd0, 2'd0, "prog_cancel");
      strobe(1'b0, 1'b1, 1'b0, ENTRY, 3'd0, 2'd0, "relock4");
      seq6(24'h518384, ENTRY, OPEN, 2'd0, 2'd0, "code_kept_after_cancel");

      strobe(1'b0, 1'b0, 1'b1, PROG, 3'd0, 2'd0, "prog_enter2");
      seq6(24'h654321, PROG, OPEN, 2'd0, 2'd0, "prog_new_code");
      strobe(1'b0, 1'b1, 1'b1, ENTRY, 3'd0, 2'd0, "relock_beats_prog");
      seq6(24'h518384, ENTRY, CLOSED, 2'd0, 2'd1, "old_code_rejected");
      strobe(1'b1, 1'b0, 1'b0, ENTRY, 3'd0, 2'd1, "cancel_new");
      seq6(24'h654321, ENTRY, OPEN, 2'd1, 2'd0, "new_code_opens");

      strobe(1'b0, 1'b0, 1'b1, PROG, 3'd0, 2'd0, "prog_enter3");
      enter_d(4'd1, PROG, 3'd1, 2'd0, 1'b0, "prog_r0");
      enter_d(4'd2, PROG, 3'd2, 2'd0, 1'b0, "prog_r1");
      enter_d(4'd3, PROG, 3'd3, 2'd0, 1'b0, "prog_r2");
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, 1'b0, "reset_mid_prog");
      strobe(1'b0, 1'b0, 1'b0, ENTRY, 3'd0, 2'd0, "idle3");
      seq6(24'h518384, ENTRY, OPEN, 2'd0, 2'd0, "default_restored");
      strobe(1'b0, 1'b0, 1'b0, OPEN, 3'd0, 2'd0, "final_idle");

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
